// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio sample path in the clk_pixel domain:
//   IEC60958_FRAMES : frames per IEC 60958 channel-status block (192)
//   audio_word_t    : 24-bit MSB-justified audio sample
//   msb_justify()   : left-aligns a narrower sample inside a 24-bit word
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam logic [7:0] IEC60958_FRAMES = 8'd192;

    typedef logic [23:0] audio_word_t;

    // The caller zero-extends the raw sample to 24 bits. Shifting it left by
    // (24 - width) places its MSB at bit 23 and zero-fills the low bits.
    function automatic audio_word_t msb_justify(input logic [23:0] sample,
                                                input int unsigned width);
        return sample << (24 - width);
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// ---------------------------------------------------------------------------
// audio_sample_fifo
// Generic synchronous FIFO with a registered head word.
//   clk, rst  : clock and synchronous active-high reset
//   wr_en     : write wr_data at the tail (caller guarantees there is room,
//               or that a read happens in the same cycle)
//   rd_en     : drop the head entry (caller guarantees the FIFO is non-empty)
//   head      : registered copy of the oldest entry, valid while not_empty
//   not_empty : registered, set when count is non-zero
//   count     : number of occupied entries
// Storage is not reset; only the pointers, the count and the head register
// are reset.
// ---------------------------------------------------------------------------
module audio_sample_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             head,
    output logic                         not_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             not_empty_q, not_empty_d;

    always_comb begin
        wr_ptr_d    = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(wr_en) - CW'(rd_en);
        not_empty_d = (count_d != '0);

        // The head register must already hold the new head next cycle. If
        // the new head slot is the one being written right now (push into an
        // empty FIFO, or push+pop at count 1), take the incoming data instead
        // of the stale memory contents.
        head_d = head_q;
        if (count_d != '0) begin
            if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
                head_d = wr_data;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
            not_empty_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            not_empty_q <= not_empty_d;
        end
    end

    // Storage: no reset, and a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign head      = head_q;
    assign not_empty = not_empty_q;
    assign count     = count_q;

endmodule

// File: rtl/audio_sample_scheduler.sv
// ---------------------------------------------------------------------------
// audio_sample_scheduler
// Buffers stereo L-PCM sample pairs and hands them to the audio sample packet
// assembler one at a time, tracking the IEC 60958 frame index of the head.
//   clk_pixel          : sole clock
//   reset              : synchronous, active-high
//   audio_sample_valid : push strobe, one pair per asserted cycle
//   audio_sample_in    : [0] left, [1] right, AUDIO_BIT_WIDTH bits each
//   packet_request     : pop strobe from the packet assembler
//   packet_available   : FIFO non-empty, head pair valid
//   audio_sample_word  : head pair, MSB-justified to 24 bits
//   frame_counter      : IEC 60958 frame index (0..191) of the head pair
//   fill_level         : occupied entries
//   overflow/underflow : sticky error flags, cleared only by reset
// ---------------------------------------------------------------------------
module audio_sample_scheduler
    import audio_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int DEPTH           = 4
) (
    input  logic                         clk_pixel,
    input  logic                         reset,
    input  logic                         audio_sample_valid,
    input  logic [AUDIO_BIT_WIDTH-1:0]   audio_sample_in [1:0],
    input  logic                         packet_request,
    output logic                         packet_available,
    output logic [23:0]                  audio_sample_word [1:0],
    output logic [7:0]                   frame_counter,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int            CW       = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0] fifo_count;
    logic          fifo_not_empty;
    logic [47:0]   fifo_head;
    logic [47:0]   wr_pair;
    logic          pop_ok;
    logic          push_ok;

    logic [7:0]    frame_counter_q, frame_counter_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    // A full FIFO still accepts a push when a pop frees the head slot in the
    // same cycle.
    assign pop_ok  = packet_request && fifo_not_empty;
    assign push_ok = audio_sample_valid && ((fifo_count != FULL_CNT) || pop_ok);

    assign wr_pair = {msb_justify(24'(audio_sample_in[1]), AUDIO_BIT_WIDTH),
                      msb_justify(24'(audio_sample_in[0]), AUDIO_BIT_WIDTH)};

    audio_sample_fifo #(
        .WIDTH (48),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_pixel),
        .rst       (reset),
        .wr_en     (push_ok),
        .rd_en     (pop_ok),
        .wr_data   (wr_pair),
        .head      (fifo_head),
        .not_empty (fifo_not_empty),
        .count     (fifo_count)
    );

    always_comb begin
        frame_counter_d = frame_counter_q;
        if (pop_ok) begin
            frame_counter_d = (frame_counter_q == IEC60958_FRAMES - 8'd1)
                              ? 8'd0 : frame_counter_q + 8'd1;
        end
        overflow_d  = overflow_q  || (audio_sample_valid && !push_ok);
        underflow_d = underflow_q || (packet_request && !fifo_not_empty);
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            frame_counter_q <= 8'd0;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            frame_counter_q <= frame_counter_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
        end
    end

    assign packet_available     = fifo_not_empty;
    assign audio_sample_word[0] = fifo_head[23:0];
    assign audio_sample_word[1] = fifo_head[47:24];
    assign fill_level           = fifo_count;
    assign frame_counter        = frame_counter_q;
    assign overflow             = overflow_q;
    assign underflow            = underflow_q;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// ---------------------------------------------------------------------------
// tb_audio_sample_scheduler
// Directed self-checking bench for audio_sample_scheduler with
// AUDIO_BIT_WIDTH=16 and DEPTH=4.
// ---------------------------------------------------------------------------
module tb_audio_sample_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        audio_sample_valid;
    logic [15:0] sin [1:0];
    logic        packet_request;
    logic        packet_available;
    logic [23:0] word [1:0];
    logic [7:0]  frame_counter;
    logic [2:0]  fill_level;
    logic        overflow;
    logic        underflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    audio_sample_scheduler #(
        .AUDIO_BIT_WIDTH (16),
        .DEPTH           (4)
    ) dut (
        .clk_pixel          (clk),
        .reset              (reset),
        .audio_sample_valid (audio_sample_valid),
        .audio_sample_in    (sin),
        .packet_request     (packet_request),
        .packet_available   (packet_available),
        .audio_sample_word  (word),
        .frame_counter      (frame_counter),
        .fill_level         (fill_level),
        .overflow           (overflow),
        .underflow          (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [15:0] l, input logic [15:0] r,
                       input logic req);
        audio_sample_valid = v;
        sin[0]             = l;
        sin[1]             = r;
        packet_request     = req;
        @(posedge clk);
        #1;
        audio_sample_valid = 1'b0;
        packet_request     = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [15:0] l, input logic [15:0] r);
        chk({tag, "_L"}, {8'h00, word[0]}, {8'h00, l, 8'h00});
        chk({tag, "_R"}, {8'h00, word[1]}, {8'h00, r, 8'h00});
    endtask

    task automatic chk_status(input string tag, input logic avail, input logic [2:0] fill,
                              input logic [7:0] fc, input logic ovf, input logic unf);
        chk({tag, "_avail"}, 32'(packet_available), 32'(avail));
        chk({tag, "_fill"},  32'(fill_level),       32'(fill));
        chk({tag, "_fc"},    32'(frame_counter),    32'(fc));
        chk({tag, "_ovf"},   32'(overflow),         32'(ovf));
        chk({tag, "_unf"},   32'(underflow),        32'(unf));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 16'h0, 16'h0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        audio_sample_valid = 1'b0;
        packet_request     = 1'b0;
        sin[0]             = 16'h0;
        sin[1]             = 16'h0;

        // Reset, with a push and pop asserted during the last reset cycle
        cyc(1'b0, 16'h0, 16'h0, 1'b0);
        cyc(1'b1, 16'hDEAD, 16'hBEEF, 1'b1);
        reset = 1'b0;
        chk_status("rst", 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
        chk_head("rst", 16'h0000, 16'h0000);

        // Single sample
        cyc(1'b1, 16'h1234, 16'hABCD, 1'b0);
        chk_head("single", 16'h1234, 16'hABCD);
        chk_status("single_push", 1'b1, 3'd1, 8'd0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1);
        chk_status("single_pop", 1'b0, 3'd0, 8'd1, 1'b0, 1'b0);

        // Overflow: five pushes into a depth-4 FIFO
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 16'(16'h1000 + i), 16'(16'h2000 + i), 1'b0);
            if (i == 4) chk_status("ovf_4", 1'b1, 3'd4, 8'd1, 1'b0, 1'b0);
        end
        chk_status("ovf_5", 1'b1, 3'd4, 8'd1, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            chk_head("ovf_pop", 16'(16'h1000 + i), 16'(16'h2000 + i));
            chk("ovf_pop_fc", 32'(frame_counter), 32'(i));
            cyc(1'b0, 16'h0, 16'h0, 1'b1);
        end
        chk_status("ovf_drain", 1'b0, 3'd0, 8'd5, 1'b1, 1'b0);

        // Underflow: pop on empty, then push+pop on empty
        cyc(1'b0, 16'h0, 16'h0, 1'b1);
        chk_status("unf_pop", 1'b0, 3'd0, 8'd5, 1'b1, 1'b1);
        cyc(1'b1, 16'h5555, 16'h6666, 1'b1);
        chk_status("unf_pushpop", 1'b1, 3'd1, 8'd5, 1'b1, 1'b1);
        chk_head("unf_pushpop", 16'h5555, 16'h6666);
        cyc(1'b0, 16'h0, 16'h0, 1'b1);
        chk_status("unf_drain", 1'b0, 3'd0, 8'd6, 1'b1, 1'b1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(16'hA000 + i), 16'(16'hB000 + i), 1'b0);
        chk_head("full_head", 16'hA001, 16'hB001);
        cyc(1'b1, 16'hA005, 16'hB005, 1'b1);
        chk_status("full_pp", 1'b1, 3'd4, 8'd1, 1'b0, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            chk_head("full_order", 16'(16'hA000 + i), 16'(16'hB000 + i));
            cyc(1'b0, 16'h0, 16'h0, 1'b1);
        end
        chk_status("full_drain", 1'b0, 3'd0, 8'd5, 1'b0, 1'b0);

        // Frame counter wrap: 193 pairs back to back
        do_reset();
        cyc(1'b1, 16'h0000, 16'hFFFF, 1'b0);
        for (int k = 0; k <= 192; k++) begin
            chk("wrap_fc", 32'(frame_counter), 32'(k % 192));
            chk("wrap_fill", 32'(fill_level), 32'd1);
            chk_head("wrap", 16'(k), ~16'(k));
            if (k < 192) cyc(1'b1, 16'(k + 1), ~16'(k + 1), 1'b1);
            else         cyc(1'b0, 16'h0, 16'h0, 1'b1);
        end
        chk_status("wrap_end", 1'b0, 3'd0, 8'd1, 1'b0, 1'b0);

        // Reset mid-stream with 3 entries and both flags set
        cyc(1'b0, 16'h0, 16'h0, 1'b1);
        for (int i = 1; i <= 5; i++) cyc(1'b1, 16'(16'hC000 + i), 16'(16'hD000 + i), 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1);
        chk_status("mid_pre", 1'b1, 3'd3, 8'd2, 1'b1, 1'b1);
        reset = 1'b1;
        cyc(1'b1, 16'h7777, 16'h8888, 1'b1);
        reset = 1'b0;
        chk_status("mid_rst", 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
        chk_head("mid_rst", 16'h0000, 16'h0000);
        cyc(1'b1, 16'h4321, 16'h8765, 1'b0);
        chk_status("mid_push", 1'b1, 3'd1, 8'd0, 1'b0, 1'b0);
        chk_head("mid_push", 16'h4321, 16'h8765);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
